burst_sched_ctrl: RTL and testbench
===================================

Name: burst_sched_ctrl

Overview:
Sequencer for the gated burst clock divider. Holds a small table of burst profiles (half-period, silence length, pulses per burst, burst count) and steps through them. It drives the divider's enable and configuration inputs, and counts completed bursts via the divider's phase-status output. Sits between the register/config interface and the divider, in the same clk domain as the divider.

Parameters:
NUM_SLOTS, 4, profile table depth (power of 2, >=2)
DIV_WIDTH, 10, width of m1 (half-period) field
REP_WIDTH, 4, width of pulses-per-burst field
PHASE2_WIDTH, 10, width of m2 (silence) field
CNT_WIDTH, 8, width of bursts-per-slot field
SETTLE, 3, cycles div_enable is held low in LOAD (>= divider enable synchroniser depth + 1)

Ports:
clk  in  1  master clock
reset  in  1  async, active-high
cfg_we  in  1  write strobe for profile table
cfg_addr  in  $clog2(NUM_SLOTS)  slot index for write/readback
cfg_m1  in  DIV_WIDTH  half-period to store
cfg_m2  in  PHASE2_WIDTH  silence length to store
cfg_rep  in  REP_WIDTH  pulses per burst to store
cfg_bursts  in  CNT_WIDTH  bursts before advancing; 0 = run slot forever
start  in  1  one-cycle pulse; begin at slot 0
stop  in  1  one-cycle pulse; abort sequence
loop_en  in  1  after last_slot, wrap to slot 0 instead of finishing
last_slot  in  $clog2(NUM_SLOTS)  final slot of sequence
phase_status  in  1  divider phase (1 = silent)
div_enable  out  1  divider enable
m1_value  out  DIV_WIDTH  to divider
m2_value  out  PHASE2_WIDTH  to divider
m1_repeat_limit  out  REP_WIDTH  to divider
busy  out  1  high in LOAD or RUN
cur_slot  out  $clog2(NUM_SLOTS)  active slot
done  out  1  one-cycle pulse at normal sequence completion

Behaviour:
- Reset: all outputs 0; every table entry 0; FSM IDLE; burst counter 0; phase_status history register 0.
- Table: writing with cfg_we stores all four fields into slot cfg_addr on the next edge; writes are allowed in any state. Divider outputs are registered copies taken only on LOAD entry, so a write to the running slot takes effect at its next LOAD.
- FSM states: IDLE, LOAD, RUN.
- IDLE: div_enable=0, busy=0. start -> LOAD with cur_slot=0.
- LOAD:
  - On entry, latch the slot's m1/m2/rep into the output registers.
  - Clear the burst counter and hold div_enable=0 for SETTLE cycles, so the divider resets through its synchroniser.
  - Then go to RUN.
- RUN:
  - div_enable=1.
  - Burst completion = rising edge of phase_status (registered previous value 0, current 1). Edges are ignored outside RUN; the history register still updates every cycle.
  - On each edge, increment the burst counter. When counter+1 == cfg_bursts of the slot (nonzero), advance.
- Advance:
  - If cur_slot != last_slot: cur_slot+1 -> LOAD.
  - Else if loop_en: cur_slot=0 -> LOAD.
  - Else: pulse done for 1 cycle, then -> IDLE.
  - cur_slot wraps modulo NUM_SLOTS. If last_slot < cur_slot, it is reached after wrap.
- Slots that never advance:
  - bursts=0 runs the slot until stop.
  - m2=0 never produces a phase_status edge, so the slot also runs until stop.
  - This is intended.
- stop: from any state -> IDLE next cycle, div_enable=0, no done pulse; cur_slot holds its last value.
- start in LOAD/RUN: ignored.
- start and stop in the same cycle: stop wins.
- Advance condition and stop in the same cycle: stop wins, no done.
- Latency:
  - start -> div_enable high = 1 + SETTLE cycles.
  - Qualifying phase_status edge -> div_enable low (LOAD) = 1 cycle.
- Reset mid-RUN: immediate div_enable=0, table cleared.

Optional Feature:
Macro BURST_SCHED_READBACK_EN.
- Defined: adds output cfg_rdata, width DIV_WIDTH+PHASE2_WIDTH+REP_WIDTH+CNT_WIDTH, packed {bursts,m2,rep,m1} of slot cfg_addr.
  - Registered, 1-cycle latency; reset 0.
  - A same-cycle write to the same address returns the old value.
  - Also adds output burst_cnt (CNT_WIDTH), the live burst counter; reset 0.
- Undefined: neither port exists; no readback logic.

Test Plan:
- Program slot0 {m1=2,m2=5,rep=3,bursts=2}, slot1 {m1=1,m2=4,rep=2,bursts=1}; last_slot=1, loop_en=0; start -> check:
  - div_enable rises 4 cycles after start;
  - slot0 outputs m1=2/m2=5/rep=2'd3;
  - slot1 loads after the 2nd phase_status rise;
  - done pulses once after slot1's 1st burst;
  - busy=0 afterwards.
- Same table, loop_en=1 -> cur_slot sequence 0,1,0,1; never done; stop mid-RUN -> div_enable=0 next cycle, busy=0, no done.
- Slot0 bursts=0 -> stays in slot0 for 20 bursts; stop exits.
- While RUN in slot0, write slot0 m1=7 -> outputs keep m1=2 until the next LOAD of slot0, then m1=7.
- start and stop asserted together in IDLE -> remains IDLE; stop coincident with final advance -> no done pulse.
- Assert reset during RUN -> all outputs 0 at once; readback (BURST_SCHED_READBACK_EN) of slot0 returns 0.

Source files
------------

// File: rtl/burst_sched_ctrl.sv
// burst_sched_ctrl: steps the burst divider through a table of burst profiles.
// Define BURST_SCHED_READBACK_EN to add the cfg_rdata and burst_cnt outputs.
module burst_sched_ctrl #(
   parameter int NUM_SLOTS    = 4,
   parameter int DIV_WIDTH    = 10,
   parameter int REP_WIDTH    = 4,
   parameter int PHASE2_WIDTH = 10,
   parameter int CNT_WIDTH    = 8,
   parameter int SETTLE       = 3
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         cfg_we,
   input  logic [$clog2(NUM_SLOTS)-1:0] cfg_addr,
   input  logic [DIV_WIDTH-1:0]         cfg_m1,
   input  logic [PHASE2_WIDTH-1:0]      cfg_m2,
   input  logic [REP_WIDTH-1:0]         cfg_rep,
   input  logic [CNT_WIDTH-1:0]         cfg_bursts,
   input  logic                         start,
   input  logic                         stop,
   input  logic                         loop_en,
   input  logic [$clog2(NUM_SLOTS)-1:0] last_slot,
   input  logic                         phase_status,
   output logic                         div_enable,
   output logic [DIV_WIDTH-1:0]         m1_value,
   output logic [PHASE2_WIDTH-1:0]      m2_value,
   output logic [REP_WIDTH-1:0]         m1_repeat_limit,
   output logic                         busy,
   output logic [$clog2(NUM_SLOTS)-1:0] cur_slot,
   output logic                         done
`ifdef BURST_SCHED_READBACK_EN
   ,
   output logic [DIV_WIDTH+PHASE2_WIDTH+REP_WIDTH+CNT_WIDTH-1:0] cfg_rdata,
   output logic [CNT_WIDTH-1:0]         burst_cnt
`endif
);

   localparam int AW = $clog2(NUM_SLOTS);
   localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

   state_t st, st_nxt;

   logic [DIV_WIDTH-1:0]    tbl_m1  [NUM_SLOTS];
   logic [PHASE2_WIDTH-1:0] tbl_m2  [NUM_SLOTS];
   logic [REP_WIDTH-1:0]    tbl_rep [NUM_SLOTS];
   logic [CNT_WIDTH-1:0]    tbl_b   [NUM_SLOTS];

   logic [AW-1:0]        slot_nxt;
   logic [SW-1:0]        settle;
   logic [CNT_WIDTH-1:0] bcnt, bcnt_inc;
   logic                 phase_prev, rise, adv, wrap, done_nxt, load_in;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_SLOTS; i++) begin
            tbl_m1[i]  <= '0;
            tbl_m2[i]  <= '0;
            tbl_rep[i] <= '0;
            tbl_b[i]   <= '0;
         end
      end else if (cfg_we) begin
         tbl_m1[cfg_addr]  <= cfg_m1;
         tbl_m2[cfg_addr]  <= cfg_m2;
         tbl_rep[cfg_addr] <= cfg_rep;
         tbl_b[cfg_addr]   <= cfg_bursts;
      end
   end

   // Burst completion is the rising edge of the divider's silent phase.
   always_comb begin
      st_nxt   = st;
      slot_nxt = cur_slot;
      done_nxt = 1'b0;
      bcnt_inc = bcnt + 1'b1;
      rise     = phase_status & ~phase_prev;
      wrap     = (cur_slot == last_slot);
      adv      = (st == RUN) && rise && (tbl_b[cur_slot] != '0)
                 && (bcnt_inc == tbl_b[cur_slot]);
      unique case (st)
         IDLE: begin
            if (start) begin
               st_nxt   = LOAD;
               slot_nxt = '0;
            end
         end
         LOAD: begin
            if (settle == SW'(SETTLE - 1)) st_nxt = RUN;
         end
         RUN: begin
            if (adv) begin
               if (!wrap) begin
                  st_nxt   = LOAD;
                  slot_nxt = cur_slot + 1'b1;
               end else if (loop_en) begin
                  st_nxt   = LOAD;
                  slot_nxt = '0;
               end else begin
                  st_nxt   = IDLE;
                  done_nxt = 1'b1;
               end
            end
         end
         default: st_nxt = IDLE;
      endcase
      if (stop) begin
         st_nxt   = IDLE;
         slot_nxt = cur_slot;
         done_nxt = 1'b0;
      end
      load_in = (st_nxt == LOAD) && (st != LOAD);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         st              <= IDLE;
         cur_slot        <= '0;
         settle          <= '0;
         bcnt            <= '0;
         phase_prev      <= 1'b0;
         done            <= 1'b0;
         m1_value        <= '0;
         m2_value        <= '0;
         m1_repeat_limit <= '0;
      end else begin
         st         <= st_nxt;
         cur_slot   <= slot_nxt;
         done       <= done_nxt;
         phase_prev <= phase_status;
         if (load_in) begin
            settle          <= '0;
            bcnt            <= '0;
            m1_value        <= tbl_m1[slot_nxt];
            m2_value        <= tbl_m2[slot_nxt];
            m1_repeat_limit <= tbl_rep[slot_nxt];
         end else begin
            if (st == LOAD) settle <= settle + 1'b1;
            if (st == RUN && rise) bcnt <= bcnt_inc;
         end
      end
   end

   assign div_enable = (st == RUN);
   assign busy       = (st != IDLE);

`ifdef BURST_SCHED_READBACK_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) cfg_rdata <= '0;
      else cfg_rdata <= {tbl_b[cfg_addr], tbl_m2[cfg_addr],
                         tbl_rep[cfg_addr], tbl_m1[cfg_addr]};
   end

   assign burst_cnt = bcnt;
`endif

endmodule

// File: tb/tb_burst_sched_ctrl.sv
// Bench for burst_sched_ctrl: directed scenarios plus randomized tables
// checked against a slot-sequence model kept in the bench.
module tb_burst_sched_ctrl;

   localparam int N  = 4;
   localparam int ST = 3;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       cfg_we = 1'b0;
   logic [1:0] cfg_addr = '0;
   logic [9:0] cfg_m1 = '0;
   logic [9:0] cfg_m2 = '0;
   logic [3:0] cfg_rep = '0;
   logic [7:0] cfg_bursts = '0;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic       loop_en = 1'b0;
   logic [1:0] last_slot = '0;
   logic       phase_status = 1'b0;
   logic       div_enable;
   logic [9:0] m1_value;
   logic [9:0] m2_value;
   logic [3:0] m1_repeat_limit;
   logic       busy;
   logic [1:0] cur_slot;
   logic       done;
`ifdef BURST_SCHED_READBACK_EN
   logic [31:0] cfg_rdata;
   logic [7:0]  burst_cnt;
   logic [31:0] rd_exp;
`endif

   int n_chk = 0;
   int n_err = 0;
   int sm1 [N];
   int sm2 [N];
   int srep[N];
   int sb  [N];
   int xm1, xm2, xrep;
   int nx;

   burst_sched_ctrl dut (
      .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
      .cfg_m1(cfg_m1), .cfg_m2(cfg_m2), .cfg_rep(cfg_rep),
      .cfg_bursts(cfg_bursts), .start(start), .stop(stop),
      .loop_en(loop_en), .last_slot(last_slot),
      .phase_status(phase_status), .div_enable(div_enable),
      .m1_value(m1_value), .m2_value(m2_value),
      .m1_repeat_limit(m1_repeat_limit), .busy(busy),
      .cur_slot(cur_slot), .done(done)
`ifdef BURST_SCHED_READBACK_EN
      , .cfg_rdata(cfg_rdata), .burst_cnt(burst_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wr(int a, int m1, int m2, int rep, int b);
      cfg_we     = 1'b1;
      cfg_addr   = 2'(a);
      cfg_m1     = 10'(m1);
      cfg_m2     = 10'(m2);
      cfg_rep    = 4'(rep);
      cfg_bursts = 8'(b);
      tick();
      cfg_we  = 1'b0;
      sm1[a]  = m1;
      sm2[a]  = m2;
      srep[a] = rep;
      sb[a]   = b;
   endtask

   task automatic clear_model();
      for (int i = 0; i < N; i++) begin
         sm1[i] = 0; sm2[i] = 0; srep[i] = 0; sb[i] = 0;
      end
   endtask

   // Called right after the edge that enters LOAD for slot s.
   task automatic enter_slot(int s);
      xm1  = sm1[s];
      xm2  = sm2[s];
      xrep = srep[s];
      chk("load_slot", cur_slot, s);
      chk("load_m1", m1_value, xm1);
      chk("load_m2", m2_value, xm2);
      chk("load_rep", m1_repeat_limit, xrep);
      chk("load_busy", busy, 1);
      for (int i = 0; i < ST; i++) begin
         chk("settle_en", div_enable, 0);
         phase_status = (i < ST - 1) ? 1'($urandom_range(1, 0)) : 1'b0;
         tick();
      end
      chk("run_en", div_enable, 1);
   endtask

   task automatic burst();
      int g;
      g = $urandom_range(3, 1);
      repeat (g) begin
         phase_status = 1'b0;
         tick();
         chk("gap_en", div_enable, 1);
      end
      phase_status = 1'b1;
      tick();
      phase_status = 1'b0;
   endtask

   // Sequence model: visit slots from 0, each for its burst count.
   task automatic play(int visits, output int nxt);
      int s;
      s   = 0;
      nxt = -1;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int v = 0; v < visits; v++) begin
         enter_slot(s);
         for (int b = 0; b < sb[s]; b++) begin
            burst();
            if (b < sb[s] - 1) begin
               chk("mid_en", div_enable, 1);
               chk("mid_slot", cur_slot, s);
               chk("mid_done", done, 0);
            end
         end
         if (s == int'(last_slot) && !loop_en) begin
            chk("fin_done", done, 1);
            chk("fin_busy", busy, 0);
            chk("fin_en", div_enable, 0);
            tick();
            chk("fin_done_clr", done, 0);
            chk("fin_busy2", busy, 0);
            nxt = -1;
            return;
         end
         chk("adv_en", div_enable, 0);
         s   = (s == int'(last_slot)) ? 0 : (s + 1) % N;
         nxt = s;
      end
   endtask

   initial begin
      clear_model();
      #2;
      chk("rst_en", div_enable, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_slot", cur_slot, 0);
      chk("rst_m1", m1_value, 0);
      chk("rst_m2", m2_value, 0);
      chk("rst_rep", m1_repeat_limit, 0);
      tick();
      tick();
      reset = 1'b0;

      // Basic two-slot sequence ending in done.
      wr(0, 2, 5, 3, 2);
      wr(1, 1, 4, 2, 1);
`ifdef BURST_SCHED_READBACK_EN
      cfg_addr = 2'd0;
      tick();
      rd_exp = {8'd2, 10'd5, 4'd3, 10'd2};
      chk("rd_slot0", cfg_rdata, rd_exp);
      cfg_addr = 2'd2;
      cfg_we = 1'b1;
      cfg_m1 = 10'd9; cfg_m2 = 10'd8; cfg_rep = 4'd7; cfg_bursts = 8'd6;
      tick();
      cfg_we = 1'b0;
      chk("rd_old", cfg_rdata, 0);
      sm1[2] = 9; sm2[2] = 8; srep[2] = 7; sb[2] = 6;
      tick();
      rd_exp = {8'd6, 10'd8, 4'd7, 10'd9};
      chk("rd_new", cfg_rdata, rd_exp);
`endif
      last_slot = 2'd1;
      loop_en   = 1'b0;
      chk("idle_busy", busy, 0);
      play(2, nx);
      chk("seq1_finished", nx == -1, 1);

      // Looping: 0,1,0,1 with no done, then stop mid-RUN.
      loop_en = 1'b1;
      play(4, nx);
      chk("loop_next", nx, 0);
      enter_slot(0);
      burst();
      chk("loop_nodone", done, 0);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk("stop_en", div_enable, 0);
      chk("stop_busy", busy, 0);
      chk("stop_done", done, 0);
      chk("stop_slot", cur_slot, 0);
      tick();
      chk("stop_done2", done, 0);

      // bursts=0 runs forever.
      wr(0, 3, 6, 1, 0);
      loop_en   = 1'b0;
      last_slot = 2'd0;
      start = 1'b1;
      tick();
      start = 1'b0;
      enter_slot(0);
      for (int i = 0; i < 20; i++) begin
         burst();
         chk("inf_en", div_enable, 1);
         chk("inf_slot", cur_slot, 0);
      end
`ifdef BURST_SCHED_READBACK_EN
      chk("inf_cnt", burst_cnt, 20);
`endif
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk("inf_stop_busy", busy, 0);

      // Write to running slot takes effect at its next LOAD.
      wr(0, 2, 5, 3, 2);
      loop_en   = 1'b1;
      last_slot = 2'd1;
      start = 1'b1;
      tick();
      start = 1'b0;
      enter_slot(0);
      wr(0, 7, 5, 3, 2);
      chk("live_m1_hold", m1_value, xm1);
      chk("live_en", div_enable, 1);
      burst();
      burst();
      enter_slot(1);
      burst();
      enter_slot(0);
      chk("live_m1_new", m1_value, 7);
      stop = 1'b1;
      tick();
      stop = 1'b0;

      // start+stop together in IDLE.
      start = 1'b1;
      stop  = 1'b1;
      tick();
      start = 1'b0;
      stop  = 1'b0;
      chk("ss_busy", busy, 0);
      chk("ss_en", div_enable, 0);

      // stop coincident with final advance.
      wr(0, 2, 5, 3, 2);
      loop_en   = 1'b0;
      last_slot = 2'd1;
      start = 1'b1;
      tick();
      start = 1'b0;
      enter_slot(0);
      burst();
      burst();
      enter_slot(1);
      phase_status = 1'b0;
      tick();
      phase_status = 1'b1;
      stop = 1'b1;
      tick();
      phase_status = 1'b0;
      stop = 1'b0;
      chk("fs_done", done, 0);
      chk("fs_busy", busy, 0);
      chk("fs_slot", cur_slot, 1);
      tick();
      chk("fs_done2", done, 0);

      // Randomized tables and sequence lengths.
      for (int r = 0; r < 4; r++) begin
         for (int a = 0; a < N; a++)
            wr(a, $urandom_range(1023, 1), $urandom_range(1023, 1),
               $urandom_range(15, 1), $urandom_range(3, 1));
         last_slot = 2'($urandom_range(3, 0));
         loop_en   = 1'b0;
         play(N, nx);
         chk("rand_finished", nx == -1, 1);
      end

      // Reset in RUN.
      last_slot = 2'd1;
      start = 1'b1;
      tick();
      start = 1'b0;
      enter_slot(0);
      #2;
      reset = 1'b1;
      #1;
      chk("mr_en", div_enable, 0);
      chk("mr_busy", busy, 0);
      chk("mr_m1", m1_value, 0);
      chk("mr_m2", m2_value, 0);
      chk("mr_rep", m1_repeat_limit, 0);
      chk("mr_slot", cur_slot, 0);
      chk("mr_done", done, 0);
      clear_model();
      tick();
      reset = 1'b0;
`ifdef BURST_SCHED_READBACK_EN
      cfg_addr = 2'd0;
      tick();
      chk("mr_rd", cfg_rdata, 0);
      chk("mr_cnt", burst_cnt, 0);
`endif
      last_slot = 2'd0;
      start = 1'b1;
      tick();
      start = 1'b0;
      enter_slot(0);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk("end_busy", busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
